// File: rtl/fwd_hazard_pkg.sv
// Shared constants, FSM encoding and helpers for the forwarding / load-use hazard unit.
package fwd_hazard_pkg;

    // ALU operand source selects
    localparam logic [1:0] FWD_RF    = 2'd0;   // register file value
    localparam logic [1:0] FWD_MEMWB = 2'd1;   // value from MEM/WB
    localparam logic [1:0] FWD_EXMEM = 2'd2;   // value from EX/MEM (youngest)

    // Load-use stall sequencer states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } fsm_state_t;

    // Widest counter the saturating helper supports
    localparam int SAT_MAX_W = 64;

    // Increment val by one, clamping at the all-ones value of a width-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] val,
        input int unsigned          width
    );
        logic [SAT_MAX_W-1:0] lim;
        if (width >= 32'(SAT_MAX_W)) begin
            lim = {SAT_MAX_W{1'b1}};
        end else begin
            lim = (64'd1 << width) - 64'd1;
        end
        if (val >= lim) begin
            sat_inc = lim;
        end else begin
            sat_inc = val + 64'd1;
        end
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Priority match for one EX-stage ALU operand: EX/MEM beats MEM/WB, x0 is never forwarded.
module fwd_select
    import fwd_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_exmem,
    input  logic                  regwrite_exmem,
    input  logic [REG_ADDR_W-1:0] rd_memwb,
    input  logic                  regwrite_memwb,
    output logic [1:0]            sel
);

    logic exmem_hit_s;
    logic memwb_hit_s;

    // Per-stage match: stage writes, target is not x0, and target equals the source
    always_comb begin
        exmem_hit_s = 1'b0;
        memwb_hit_s = 1'b0;
        if (regwrite_exmem && (rd_exmem != {REG_ADDR_W{1'b0}}) && (rd_exmem == rs)) begin
            exmem_hit_s = 1'b1;
        end else begin
            exmem_hit_s = 1'b0;
        end
        if (regwrite_memwb && (rd_memwb != {REG_ADDR_W{1'b0}}) && (rd_memwb == rs)) begin
            memwb_hit_s = 1'b1;
        end else begin
            memwb_hit_s = 1'b0;
        end
    end

    // Youngest producer wins; encoding 3 can never be produced
    always_comb begin
        sel = FWD_RF;
        if (exmem_hit_s) begin
            sel = FWD_EXMEM;
        end else if (memwb_hit_s) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects, load-use hazard stall sequencer and saturating performance counters.
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  freeze,
    input  logic [REG_ADDR_W-1:0] rs1_ID,
    input  logic [REG_ADDR_W-1:0] rs2_ID,
    input  logic                  use_rs1_ID,
    input  logic                  use_rs2_ID,
    input  logic [REG_ADDR_W-1:0] rs1_EX,
    input  logic [REG_ADDR_W-1:0] rs2_EX,
    input  logic [REG_ADDR_W-1:0] rd_IDEX,
    input  logic                  regwrite_IDEX,
    input  logic                  memread_IDEX,
    input  logic [REG_ADDR_W-1:0] rd_EXMEM,
    input  logic                  regwrite_EXMEM,
    input  logic [REG_ADDR_W-1:0] rd_MEMWB,
    input  logic                  regwrite_MEMWB,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  flush_idex,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      fwd_cycles
);

    // Remaining-stall counter must hold LOAD_LATENCY-1
    localparam int REMAIN_W = (LOAD_LATENCY < 2) ? 1 : $clog2(LOAD_LATENCY + 1);
    localparam logic [REMAIN_W-1:0] REMAIN_INIT = REMAIN_W'(LOAD_LATENCY - 1);
    localparam logic [REMAIN_W-1:0] REMAIN_ONE  = REMAIN_W'(1);
    localparam logic [REMAIN_W-1:0] REMAIN_ZERO = {REMAIN_W{1'b0}};
    localparam bit MULTI_CYCLE = (LOAD_LATENCY > 1);

    fsm_state_t            state_r;
    fsm_state_t            state_nxt_s;
    logic [REMAIN_W-1:0]   remain_r;
    logic [REMAIN_W-1:0]   remain_nxt_s;
    logic                  hz_s;
    logic                  rs1_hit_s;
    logic                  rs2_hit_s;
    logic                  stall_s;
    logic [1:0]            fwd_a_s;
    logic [1:0]            fwd_b_s;
    logic                  fwd_any_s;
    logic [CNT_W-1:0]      stall_cnt_r;
    logic [CNT_W-1:0]      fwd_cnt_r;
    logic [CNT_W-1:0]      stall_cnt_nxt_s;
    logic [CNT_W-1:0]      fwd_cnt_nxt_s;

    fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_sel_a (
        .rs             (rs1_EX),
        .rd_exmem       (rd_EXMEM),
        .regwrite_exmem (regwrite_EXMEM),
        .rd_memwb       (rd_MEMWB),
        .regwrite_memwb (regwrite_MEMWB),
        .sel            (fwd_a_s)
    );

    fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_sel_b (
        .rs             (rs2_EX),
        .rd_exmem       (rd_EXMEM),
        .regwrite_exmem (regwrite_EXMEM),
        .rd_memwb       (rd_MEMWB),
        .regwrite_memwb (regwrite_MEMWB),
        .sel            (fwd_b_s)
    );

    assign forward_a = fwd_a_s;
    assign forward_b = fwd_b_s;

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        rs1_hit_s = use_rs1_ID && (rd_IDEX == rs1_ID);
        rs2_hit_s = use_rs2_ID && (rd_IDEX == rs2_ID);
        if (memread_IDEX && regwrite_IDEX && (rd_IDEX != {REG_ADDR_W{1'b0}})) begin
            hz_s = rs1_hit_s || rs2_hit_s;
        end else begin
            hz_s = 1'b0;
        end
    end

    // Stall sequencer next state; hz is only looked at in IDLE since ID/EX holds a bubble in STALL
    always_comb begin
        state_nxt_s  = state_r;
        remain_nxt_s = remain_r;
        stall_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_s = hz_s;
                if (hz_s && MULTI_CYCLE) begin
                    state_nxt_s  = ST_STALL;
                    remain_nxt_s = REMAIN_INIT;
                end else begin
                    state_nxt_s  = ST_IDLE;
                    remain_nxt_s = REMAIN_ZERO;
                end
            end
            ST_STALL: begin
                stall_s = 1'b1;
                if (remain_r <= REMAIN_ONE) begin
                    state_nxt_s  = ST_IDLE;
                    remain_nxt_s = REMAIN_ZERO;
                end else begin
                    state_nxt_s  = ST_STALL;
                    remain_nxt_s = remain_r - REMAIN_ONE;
                end
            end
            default: begin
                stall_s      = 1'b0;
                state_nxt_s  = ST_IDLE;
                remain_nxt_s = REMAIN_ZERO;
            end
        endcase
    end

    // Stall controls follow the sequencer but are forced low while reset is applied
    always_comb begin
        if (arst) begin
            stall_pc   = 1'b0;
            stall_ifid = 1'b0;
            flush_idex = 1'b0;
        end else begin
            stall_pc   = stall_s;
            stall_ifid = stall_s;
            flush_idex = stall_s;
        end
    end

    // Counter next values: one step per qualifying cycle, clamped at all-ones
    always_comb begin
        fwd_any_s = (fwd_a_s != FWD_RF) || (fwd_b_s != FWD_RF);
        if (stall_s) begin
            stall_cnt_nxt_s = CNT_W'(sat_inc(SAT_MAX_W'(stall_cnt_r), CNT_W));
        end else begin
            stall_cnt_nxt_s = stall_cnt_r;
        end
        if (fwd_any_s) begin
            fwd_cnt_nxt_s = CNT_W'(sat_inc(SAT_MAX_W'(fwd_cnt_r), CNT_W));
        end else begin
            fwd_cnt_nxt_s = fwd_cnt_r;
        end
    end

    // Sequencer and counter state; a memory freeze holds everything in place
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r     <= ST_IDLE;
            remain_r    <= REMAIN_ZERO;
            stall_cnt_r <= {CNT_W{1'b0}};
            fwd_cnt_r   <= {CNT_W{1'b0}};
        end else if (freeze) begin
            state_r     <= state_r;
            remain_r    <= remain_r;
            stall_cnt_r <= stall_cnt_r;
            fwd_cnt_r   <= fwd_cnt_r;
        end else begin
            state_r     <= state_nxt_s;
            remain_r    <= remain_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
            fwd_cnt_r   <= fwd_cnt_nxt_s;
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign fwd_cycles   = fwd_cnt_r;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: two instances (LOAD_LATENCY=3/CNT_W=4 and LOAD_LATENCY=1/CNT_W=32)
// share stimulus and are compared each cycle against a behavioural model.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       freeze;
    logic [4:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_IDEX, rd_EXMEM, rd_MEMWB;
    logic       use_rs1_ID, use_rs2_ID, regwrite_IDEX, memread_IDEX;
    logic       regwrite_EXMEM, regwrite_MEMWB;

    logic [1:0]  fa3, fb3, fa1, fb1;
    logic        sp3, si3, fl3, sp1, si1, fl1;
    logic [3:0]  sc3, fc3;
    logic [31:0] sc1, fc1;

    int n_cmp  = 0;
    int n_fail = 0;
    int hi3    = 0;

    // model state: remaining stall cycles after the current one, and counter values
    int              busy3, busy1;
    longint unsigned m_sc3, m_fc3, m_sc1, m_fc1;
    localparam longint unsigned MAX3 = 64'd15;
    localparam longint unsigned MAX1 = 64'hFFFF_FFFF;

    logic [1:0] e_fa, e_fb;
    logic       e_st3, e_st1;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .arst(arst), .freeze(freeze),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_IDEX(rd_IDEX),
        .regwrite_IDEX(regwrite_IDEX), .memread_IDEX(memread_IDEX),
        .rd_EXMEM(rd_EXMEM), .regwrite_EXMEM(regwrite_EXMEM),
        .rd_MEMWB(rd_MEMWB), .regwrite_MEMWB(regwrite_MEMWB),
        .forward_a(fa3), .forward_b(fb3), .stall_pc(sp3), .stall_ifid(si3),
        .flush_idex(fl3), .stall_cycles(sc3), .fwd_cycles(fc3)
    );

    fwd_hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .arst(arst), .freeze(freeze),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_IDEX(rd_IDEX),
        .regwrite_IDEX(regwrite_IDEX), .memread_IDEX(memread_IDEX),
        .rd_EXMEM(rd_EXMEM), .regwrite_EXMEM(regwrite_EXMEM),
        .rd_MEMWB(rd_MEMWB), .regwrite_MEMWB(regwrite_MEMWB),
        .forward_a(fa1), .forward_b(fb1), .stall_pc(sp1), .stall_ifid(si1),
        .flush_idex(fl1), .stall_cycles(sc1), .fwd_cycles(fc1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (regwrite_EXMEM && rd_EXMEM != 5'd0 && rd_EXMEM == rs) return 2'd2;
        if (regwrite_MEMWB && rd_MEMWB != 5'd0 && rd_MEMWB == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic ref_hz();
        if (!(memread_IDEX && regwrite_IDEX) || rd_IDEX == 5'd0) return 1'b0;
        return (use_rs1_ID && rd_IDEX == rs1_ID) || (use_rs2_ID && rd_IDEX == rs2_ID);
    endfunction

    task automatic model_reset();
        busy3 = 0; busy1 = 0;
        m_sc3 = 0; m_fc3 = 0; m_sc1 = 0; m_fc1 = 0;
    endtask

    task automatic clear_inputs();
        rs1_ID = 5'd0; rs2_ID = 5'd0; rs1_EX = 5'd0; rs2_EX = 5'd0;
        rd_IDEX = 5'd0; rd_EXMEM = 5'd0; rd_MEMWB = 5'd0;
        use_rs1_ID = 1'b0; use_rs2_ID = 1'b0; regwrite_IDEX = 1'b0; memread_IDEX = 1'b0;
        regwrite_EXMEM = 1'b0; regwrite_MEMWB = 1'b0;
    endtask

    task automatic set_hazard();
        memread_IDEX = 1'b1; regwrite_IDEX = 1'b1; rd_IDEX = 5'd7;
        rs2_ID = 5'd7; use_rs2_ID = 1'b1;
    endtask

    // One clock: compare all outputs mid-cycle, then advance the model at the edge
    task automatic cycle();
        #3;
        if (arst) model_reset();
        e_fa  = ref_fwd(rs1_EX);
        e_fb  = ref_fwd(rs2_EX);
        e_st3 = !arst && (busy3 > 0 || ref_hz());
        e_st1 = !arst && (busy1 > 0 || ref_hz());
        chk("fa3", 64'(fa3), 64'(e_fa));  chk("fb3", 64'(fb3), 64'(e_fb));
        chk("fa1", 64'(fa1), 64'(e_fa));  chk("fb1", 64'(fb1), 64'(e_fb));
        chk("sp3", 64'(sp3), 64'(e_st3)); chk("si3", 64'(si3), 64'(e_st3));
        chk("fl3", 64'(fl3), 64'(e_st3)); chk("sp1", 64'(sp1), 64'(e_st1));
        chk("si1", 64'(si1), 64'(e_st1)); chk("fl1", 64'(fl1), 64'(e_st1));
        chk("sc3", 64'(sc3), m_sc3);      chk("fc3", 64'(fc3), m_fc3);
        chk("sc1", 64'(sc1), m_sc1);      chk("fc1", 64'(fc1), m_fc1);
        hi3 += int'(sp3);
        @(posedge clk);
        if (arst) begin
            model_reset();
        end else if (!freeze) begin
            if (e_st3 && m_sc3 < MAX3) m_sc3++;
            if (e_st1 && m_sc1 < MAX1) m_sc1++;
            if ((e_fa != 2'd0 || e_fb != 2'd0) && m_fc3 < MAX3) m_fc3++;
            if ((e_fa != 2'd0 || e_fb != 2'd0) && m_fc1 < MAX1) m_fc1++;
            if (busy3 > 0) busy3--; else if (e_st3) busy3 = 3 - 1;
            if (busy1 > 0) busy1--; else if (e_st1) busy1 = 1 - 1;
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        freeze = 1'b0;
        arst = 1'b1;
        cycle();
        arst = 1'b0;
        hi3 = 0;
    endtask

    initial begin
        clear_inputs();
        freeze = 1'b0;
        model_reset();
        #1 arst = 1'b1;
        cycle();
        cycle();
        chk("rst_sc3", 64'(sc3), 64'd0);
        chk("rst_sp3", 64'(sp3), 64'd0);
        arst = 1'b0;

        // forwarding priority: both stages match, then only MEM/WB
        rs1_EX = 5'd5; rd_EXMEM = 5'd5; rd_MEMWB = 5'd5;
        regwrite_EXMEM = 1'b1; regwrite_MEMWB = 1'b1;
        #1 chk("prio_both", 64'(fa3), 64'd2);
        cycle();
        regwrite_EXMEM = 1'b0;
        #1 chk("prio_memwb", 64'(fa3), 64'd1);
        cycle();

        // x0 is never forwarded and does not count
        clear_inputs();
        rs1_EX = 5'd3; rs2_EX = 5'd0; rd_EXMEM = 5'd0; regwrite_EXMEM = 1'b1;
        #1 chk("x0_fb", 64'(fb3), 64'd0);
        cycle();
        cycle();
        chk("x0_fc", 64'(fc3), 64'd2);

        // load-use: unused operand gives no stall, used operand stalls
        do_reset();
        set_hazard();
        use_rs2_ID = 1'b0;
        #1 chk("nouse_sp1", 64'(sp1), 64'd0);
        cycle();
        use_rs2_ID = 1'b1;
        #1 chk("lu_sp1", 64'(sp1), 64'd1);
        cycle();
        clear_inputs();
        #1 chk("lu1_end", 64'(sp1), 64'd0);
        repeat (4) cycle();
        chk("lu_sc1", 64'(sc1), 64'd1);
        chk("lu_sc3", 64'(sc3), 64'd3);
        chk("lu_hi3", 64'(hi3), 64'd3);

        // back-to-back: hazard still present on first idle cycle
        do_reset();
        set_hazard();
        repeat (4) cycle();
        clear_inputs();
        repeat (4) cycle();
        chk("b2b_sc3", 64'(sc3), 64'd6);
        chk("b2b_hi3", 64'(hi3), 64'd6);
        chk("b2b_sc1", 64'(sc1), 64'd4);

        // freeze for 4 cycles from the second stall cycle
        do_reset();
        set_hazard();
        cycle();
        clear_inputs();
        freeze = 1'b1;
        repeat (4) cycle();
        freeze = 1'b0;
        repeat (4) cycle();
        chk("frz_hi3", 64'(hi3), 64'd7);
        chk("frz_sc3", 64'(sc3), 64'd3);

        // asynchronous reset in the middle of a stall
        set_hazard();
        cycle();
        clear_inputs();
        cycle();
        #1 arst = 1'b1;
        #1;
        chk("arst_sp3", 64'(sp3), 64'd0);
        chk("arst_si3", 64'(si3), 64'd0);
        chk("arst_fl3", 64'(fl3), 64'd0);
        chk("arst_sc3", 64'(sc3), 64'd0);
        chk("arst_fc3", 64'(fc3), 64'd0);
        model_reset();
        cycle();
        arst = 1'b0;
        cycle();

        // saturation of the 4-bit forwarding counter
        do_reset();
        rs1_EX = 5'd9; rd_EXMEM = 5'd9; regwrite_EXMEM = 1'b1;
        repeat (20) cycle();
        chk("sat_fc3", 64'(fc3), 64'd15);
        chk("sat_fc1", 64'(fc1), 64'd20);
        cycle();
        chk("sat_hold", 64'(fc3), 64'd15);

        // randomized traffic with small register numbers to provoke matches
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rs1_ID = 5'($urandom_range(0, 3)); rs2_ID = 5'($urandom_range(0, 3));
            rs1_EX = 5'($urandom_range(0, 3)); rs2_EX = 5'($urandom_range(0, 3));
            rd_IDEX = 5'($urandom_range(0, 3)); rd_EXMEM = 5'($urandom_range(0, 3));
            rd_MEMWB = 5'($urandom_range(0, 3));
            use_rs1_ID = 1'($urandom_range(0, 1)); use_rs2_ID = 1'($urandom_range(0, 1));
            regwrite_IDEX = 1'($urandom_range(0, 1));
            memread_IDEX = ($urandom_range(0, 2) == 0);
            regwrite_EXMEM = 1'($urandom_range(0, 1)); regwrite_MEMWB = 1'($urandom_range(0, 1));
            freeze = ($urandom_range(0, 4) == 0);
            arst = ($urandom_range(0, 59) == 0);
            cycle();
        end
        arst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the 5-stage pipeline. Selects an operand source for each EX-stage ALU input, with EX/MEM taking priority over MEM/WB and register x0 never forwarded. Detects load-use hazards in ID and stalls IF/ID while bubbling ID/EX for a configurable number of cycles through a small FSM. Keeps saturating performance counters for stall cycles and forwarding cycles.

Parameters:
REG_ADDR_W, 5, width of register specifiers
LOAD_LATENCY, 1, stall cycles per load-use hazard (>=1)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  pipeline clock
arst  in  1  asynchronous reset, active-high
freeze  in  1  global pipeline freeze (memory wait); FSM and counters hold
rs1_ID  in  REG_ADDR_W  source 1 of instruction in ID
rs2_ID  in  REG_ADDR_W  source 2 of instruction in ID
use_rs1_ID  in  1  ID instruction reads rs1
use_rs2_ID  in  1  ID instruction reads rs2
rs1_EX  in  REG_ADDR_W  source 1 of instruction in EX (ID/EX register)
rs2_EX  in  REG_ADDR_W  source 2 of instruction in EX
rd_IDEX  in  REG_ADDR_W  destination of instruction in EX
regwrite_IDEX  in  1  EX instruction writes the register file
memread_IDEX  in  1  EX instruction is a load
rd_EXMEM  in  REG_ADDR_W  destination in EX/MEM
regwrite_EXMEM  in  1  EX/MEM writes the register file
rd_MEMWB  in  REG_ADDR_W  destination in MEM/WB
regwrite_MEMWB  in  1  MEM/WB writes the register file
forward_a  out  2  ALU input A select: 0 reg file, 1 MEM/WB, 2 EX/MEM
forward_b  out  2  ALU input B select, same encoding
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID register
flush_idex  out  1  insert bubble into ID/EX
stall_cycles  out  CNT_W  saturating count of cycles with stall_pc=1
fwd_cycles  out  CNT_W  saturating count of cycles with any forward_x!=0

Behaviour:
- Forwarding is combinational, zero latency, and is evaluated per operand independently.
- For operand A: 2 if regwrite_EXMEM && rd_EXMEM!=0 && rd_EXMEM==rs1_EX; otherwise 1 if regwrite_MEMWB && rd_MEMWB!=0 && rd_MEMWB==rs1_EX; otherwise 0. Operand B uses the same rule with rs2_EX.
- Both stages matching the same register gives 2 (youngest value wins). Encoding 3 is never produced.
- Every output has a defined value on every path; there are no inferred latches.
- Hazard detect (hz), combinational: memread_IDEX && regwrite_IDEX && rd_IDEX!=0 && ((use_rs1_ID && rd_IDEX==rs1_ID) || (use_rs2_ID && rd_IDEX==rs2_ID)).
- FSM has states IDLE and STALL. A down-counter remain has width clog2(LOAD_LATENCY+1).
- In IDLE:
  - If hz=1, stall_pc, stall_ifid and flush_idex are asserted in the same cycle.
  - If LOAD_LATENCY>1, the next state is STALL with remain=LOAD_LATENCY-1; otherwise the FSM stays in IDLE.
- In STALL:
  - The three stall outputs are asserted and remain decrements each cycle.
  - When remain==1, the next state is IDLE.
  - hz is ignored in STALL, because ID/EX holds a bubble.
- When freeze=1, the FSM state, remain and both counters hold. Stall outputs keep their current combinational value. Forwarding is unaffected.
- Back-to-back hazards: a new hz in the first IDLE cycle after a stall starts a new stall sequence.
- Counters increment by 1 per qualifying cycle when freeze=0 and saturate at all-ones.
- Reset (async, active-high): state=IDLE, remain=0, stall_cycles=0, fwd_cycles=0. While arst=1, stall_pc, stall_ifid and flush_idex are 0.
- Reset asserted mid-stall aborts the stall immediately.

Decomposition:
- Package fwd_hazard_pkg:
  - Forward-select constants FWD_RF=2'd0, FWD_MEMWB=2'd1, FWD_EXMEM=2'd2.
  - FSM state encoding ST_IDLE and ST_STALL.
  - A saturating-increment helper function.
- Sub-module fwd_select: one operand's priority match; instantiated twice (rs1_EX, rs2_EX).
- The FSM and counters stay in the top module.

Test Plan:
- Forward priority: rs1_EX=5, rd_EXMEM=5 and rd_MEMWB=5 with both regwrite=1 -> forward_a=2. Then set regwrite_EXMEM=0 -> forward_a=1.
- x0 guard: rs2_EX=0, rd_EXMEM=0, regwrite_EXMEM=1 -> forward_b=0. Also check fwd_cycles does not increment.
- Load-use, LOAD_LATENCY=1: memread_IDEX=1, rd_IDEX=7, rs2_ID=7, use_rs2_ID=1 -> stall outputs high for exactly 1 cycle, stall_cycles=1. With use_rs2_ID=0 -> no stall.
- Load-use, LOAD_LATENCY=3: same hazard -> stall outputs high for exactly 3 consecutive cycles. Then, with hz held high at the first IDLE cycle, a second 3-cycle stall follows; stall_cycles=6.
- Freeze and reset: LOAD_LATENCY=3, freeze=1 during the second stall cycle for 4 cycles -> stall extends to 7 cycles total with stall_cycles=3. Asserting arst mid-stall -> outputs drop to 0 asynchronously, counters read 0.
- Saturation: CNT_W=4, hold a forwarding condition for 20 cycles -> fwd_cycles=15 and stays at 15.
